// File: rtl/hf_mode_sequencer.sv
// hf_mode_sequencer: SPI-configured major/minor mode sequencer with frame drain and all-off guard gap
module hf_mode_sequencer #(
    parameter int GUARD_CYCLES  = 16,
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic       ck_1356meg,
    input  logic       nreset,
    input  logic       spck,
    input  logic       mosi,
    input  logic       ncs,
    input  logic       ssp_frame,
    output logic [2:0] major_mode,
    output logic [4:0] minor_conf,
    output logic       mode_busy,
    output logic       bad_cmd
);
    typedef enum logic [1:0] {IDLE, DRAIN, OFF, APPLY} state_t;
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT);
    localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);
    state_t      state, state_nxt;
    logic [1:0]  spck_s, mosi_s, ncs_s;
    logic        spck_d, ncs_d, bit_stb, ncs_rise, ncs_fall, mosi_q;
    logic [15:0] shift_reg, shift_nxt;
    logic [4:0]  bit_cnt, cnt_nxt;
    logic [7:0]  pending, pending_nxt;
    logic        pend_valid, word_ok, from_off, ssp_prev, frame_edge;
    logic [7:0]  drain_cnt, guard_cnt;
    // Bit strobe is qualified with the previous ncs level so a final spck edge
    // that lands together with ncs rising is still shifted in.
    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            spck_s   <= 2'b00;
            mosi_s   <= 2'b00;
            ncs_s    <= 2'b11;
            spck_d   <= 1'b0;
            ncs_d    <= 1'b1;
            bit_stb  <= 1'b0;
            ncs_rise <= 1'b0;
            ncs_fall <= 1'b0;
            mosi_q   <= 1'b0;
        end else begin
            spck_s   <= {spck_s[0], spck};
            mosi_s   <= {mosi_s[0], mosi};
            ncs_s    <= {ncs_s[0], ncs};
            spck_d   <= spck_s[1];
            ncs_d    <= ncs_s[1];
            bit_stb  <= spck_s[1] & ~spck_d & ~ncs_d;
            ncs_rise <= ncs_s[1] & ~ncs_d;
            ncs_fall <= ~ncs_s[1] & ncs_d;
            mosi_q   <= mosi_s[1];
        end
    end
    always_comb begin
        shift_nxt   = bit_stb ? {shift_reg[14:0], mosi_q} : shift_reg;
        cnt_nxt     = (bit_stb && bit_cnt != 5'd31) ? bit_cnt + 5'd1 : bit_cnt;
        word_ok     = ncs_rise && cnt_nxt == 5'd16 && shift_nxt[15:12] == 4'b0001;
        pending_nxt = word_ok ? shift_nxt[7:0] : pending;
    end
    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
            bad_cmd    <= 1'b0;
        end else begin
            shift_reg  <= shift_nxt;
            bit_cnt    <= ncs_fall ? 5'd0 : cnt_nxt;
            pending    <= pending_nxt;
            pend_valid <= word_ok | (pend_valid & (state != APPLY));
            bad_cmd    <= ncs_rise & (cnt_nxt != 5'd16);
        end
    end
    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            ssp_prev  <= 1'b0;
            drain_cnt <= '0;
            guard_cnt <= '0;
            from_off  <= 1'b0;
        end else begin
            state     <= state_nxt;
            ssp_prev  <= ssp_frame;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 8'd1 : 8'd0;
            guard_cnt <= (state == OFF) ? guard_cnt + 8'd1 : 8'd0;
            from_off  <= state == OFF;
        end
    end
    // A frame edge in the first DRAIN cycle belongs to the frame already running.
    assign frame_edge = ssp_frame & ~ssp_prev & (drain_cnt != 8'd0);
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (pend_valid && !word_ok)
                       state_nxt = (pending[7:5] == major_mode) ? APPLY :
                                   (major_mode == 3'b111) ? OFF : DRAIN;
            DRAIN: if (frame_edge || drain_cnt == DRAIN_LAST) state_nxt = OFF;
            OFF:   if (guard_cnt == GUARD_LAST) state_nxt = APPLY;
            APPLY: state_nxt = IDLE;
        endcase
    end
    always_comb mode_busy = (state == DRAIN) || (state == OFF) || (state == APPLY && from_off);
    // Leaving OFF applies the freshest word so the all-off gap ends exactly after the guard.
    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            major_mode <= 3'b111;
            minor_conf <= '0;
        end else if (state_nxt == OFF && state != OFF) begin
            major_mode <= 3'b111;
        end else if (state == OFF && state_nxt == APPLY) begin
            {major_mode, minor_conf} <= pending_nxt;
        end else if (state == APPLY) begin
            {major_mode, minor_conf} <= pending;
        end
    end
endmodule

// File: doc/hf_mode_sequencer.md
# hf_mode_sequencer

Configuration controller for the HF FPGA image. It receives 16-bit configuration words from the ARM over the SPI pins (`spck`, `mosi`, `ncs`) and synchronises them into the `ck_1356meg` domain. It then sequences changes of the 3-bit major mode so that no mode hands over the coil drivers and SSP mid-frame, and the shared outputs never switch between two active modes without an all-off gap. Its `major_mode` and `minor_conf` outputs drive the per-mode select muxes and the mode option bits.

## Interface
Parameters:
- `GUARD_CYCLES`, default 16: cycles `major_mode` is held at 3'b111 (all off) between two modes; legal range 1..255.
- `DRAIN_TIMEOUT`, default 255: maximum cycles spent waiting for a frame boundary; legal range 1..255.

Ports (one clock; reset is asynchronous and active-low):
- `ck_1356meg` in 1: system clock; all state is on the rising edge.
- `nreset` in 1: asynchronous active-low reset.
- `spck` in 1: SPI clock from the ARM; asynchronous to `ck_1356meg`.
- `mosi` in 1: SPI data, MSB first; asynchronous.
- `ncs` in 1: SPI chip select, active low; asynchronous.
- `ssp_frame` in 1: frame strobe of the currently selected mode, synchronous to `ck_1356meg`.
- `major_mode` out 3: applied major mode; 3'b111 means everything off.
- `minor_conf` out 5: applied `conf_word[4:0]`.
- `mode_busy` out 1: high while a major-mode change is in progress.
- `bad_cmd` out 1: one-cycle pulse when an SPI transfer is malformed.

## Operation
- **SPI front end.** `spck`, `mosi` and `ncs` each pass through a 2-flop synchroniser, followed by a registered edge detector. The ARM guarantees an `spck` half-period of at least 4 `ck_1356meg` cycles.
- **Bit capture.** On each synchronised `spck` rising edge while synchronised `ncs`=0: shift `mosi` into `shift_reg[0]` (`shift_reg` is 16 bits) and increment `bit_cnt` (5 bits, saturating at 31).
- **Transfer start.** A synchronised `ncs` falling edge clears `bit_cnt`.
- **Transfer end.** On a synchronised `ncs` rising edge:
  - `bit_cnt`≠16: discard the word and pulse `bad_cmd`.
  - `bit_cnt`=16 and `shift_reg[15:12]`=4'b0001: latch `shift_reg[7:0]` into `pending` and set `pend_valid`.
  - Any other command code: ignore silently, no `bad_cmd`.
- **Pending overwrite.** A newer `pending` word overwrites an older one at any time. APPLY always uses the latest word.
- **FSM states:** IDLE, DRAIN, OFF, APPLY.
  - IDLE, `pend_valid`, `pending[7:5]`==`major_mode`: go to APPLY (minor-only change).
  - IDLE, `pend_valid`, `major_mode`==3'b111: go to OFF (nothing to drain).
  - IDLE, `pend_valid`, otherwise: go to DRAIN.
  - DRAIN: wait for a rising edge of `ssp_frame` (registered previous value) or for the drain counter to reach `DRAIN_TIMEOUT`. Then load the guard counter and go to OFF.
  - OFF: `major_mode`=3'b111 and `minor_conf` are unchanged. Count `GUARD_CYCLES`, then go to APPLY.
  - APPLY (1 cycle): `major_mode`←`pending[7:5]`, `minor_conf`←`pending[4:0]`, clear `pend_valid`, go to IDLE.
  - If a new word arrives in APPLY, `pend_valid` stays set and the FSM starts a new sequence from IDLE.
- **`mode_busy`.** Equals 1 in DRAIN, OFF and APPLY when that APPLY was entered from OFF; 0 otherwise.

## Timing
- **Reset values:** `major_mode`=3'b111, `minor_conf`=0, `mode_busy`=0, `bad_cmd`=0, FSM=IDLE, `pend_valid`=0, `shift_reg`=0, `bit_cnt`=0; synchroniser flops reset to `ncs`=1 and `spck`=0. Reset asserted mid-sequence aborts it and the outputs return to the reset values immediately.
- **Detection latency:** the `ncs` pin rising produces the internal edge 3 cycles later; `pend_valid` is set on the 4th cycle.
- **Minor-only change:** outputs update 2 cycles after `pend_valid` sets (IDLE→APPLY, then the APPLY register update).
- **Major change:** DRAIN occupies k+1 cycles, where k is the number of cycles until the frame edge (or `DRAIN_TIMEOUT`). OFF then lasts exactly `GUARD_CYCLES` cycles with `major_mode`=3'b111, after which APPLY updates the outputs.
- **Simultaneous events:**
  - `ssp_frame` edge in the same cycle DRAIN is entered: the edge is not counted; the next edge is required.
  - `ncs` rising together with a final `spck` edge: the bit is shifted first, then the transfer is evaluated.
- **Counter widths:** 8 bits, no wrap; terminal counts are compared with ==.

## Test plan
- **Reset:** assert `nreset`=0 mid-transfer → `major_mode`=3'b111, `minor_conf`=0, `mode_busy`=0; after release, a new SPI word 0x1025 applies normally.
- **Minor-only change:** apply 0x1025 (mode 001, minor 5), then send 0x1023 → `minor_conf`=3 and `major_mode` stays 001 with no 111 gap; `mode_busy` never rises.
- **Major change:** from mode 001, send 0x1040 with `ssp_frame` pulsing every 32 cycles → `major_mode` stays 001 until the next frame edge, then holds 111 for exactly 16 cycles, then 010; `mode_busy` is high for the whole interval.
- **Drain timeout:** from mode 001, send 0x1060 with `ssp_frame` stuck at 0 → 111 after 256 DRAIN cycles, then 16 guard cycles, then 011.
- **Malformed and ignored words:** a 15-bit and a 17-bit transfer → one `bad_cmd` pulse each and outputs unchanged; a 16-bit word 0x2040 → ignored with no pulse.
- **Overwrite during a sequence:** send 0x1040 then 0x1080 during OFF → the final `major_mode`=100, applied without a second gap, with 010 never applied.
